// File: rtl/cic_comp_pkg.sv
// Shared state type, default coefficients and sizing helper for the CIC compensation FIR.
package cic_comp_pkg;

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    localparam int unsigned COEF_LEN = 32;

    // Droop-compensation taps for CW=16 (DC gain exactly 1); entries past the tap count are zero.
    localparam int COEF [COEF_LEN] = '{
        -512, 1536, -4608, 19968, 19968, -4608, 1536, -512,
        0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0
    };

    function automatic int unsigned acc_width(int unsigned dw, int unsigned cw,
                                              int unsigned taps);
        return dw + cw + $clog2(taps);
    endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Multiply-accumulate unit with round-half-up output stage.
// CIC_COMP_SAT_EN selects saturation of the rounded result; otherwise it wraps to DW bits.
module cic_comp_mac #(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 16,
    parameter int unsigned TAPS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [DW-1:0] x_i,
    input  logic signed [CW-1:0] coef_i,
    output logic signed [DW-1:0] result_o
);
    import cic_comp_pkg::*;

    localparam int unsigned AW = acc_width(DW, CW, TAPS);
    localparam int unsigned PW = DW + CW;
    localparam logic signed [AW-1:0] RND = AW'(1) << (CW - 2);

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc_d, acc_q;
    logic signed [AW-1:0] acc_rnd, shifted;

    always_comb begin
        prod  = PW'(x_i) * PW'(coef_i);
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + AW'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    always_comb begin
        acc_rnd = acc_q + RND;
        shifted = acc_rnd >>> (CW - 1);
    end

`ifdef CIC_COMP_SAT_EN
    localparam logic signed [AW-1:0] OUT_MAX = AW'(2 ** (DW - 1) - 1);
    localparam logic signed [AW-1:0] OUT_MIN = ~OUT_MAX;

    always_comb begin
        result_o = shifted[DW-1:0];
        if (shifted > OUT_MAX) begin
            result_o = OUT_MAX[DW-1:0];
        end else if (shifted < OUT_MIN) begin
            result_o = OUT_MIN[DW-1:0];
        end
    end
`else
    logic unused_shift_hi;

    assign unused_shift_hi = ^shifted[AW-1:DW];
    assign result_o        = shifted[DW-1:0];
`endif

endmodule

// File: rtl/cic_comp_fir.sv
// Symmetric compensation FIR after the CIC decimator, one MAC reused across all taps.
// Output clamping is enabled by defining CIC_COMP_SAT_EN (see cic_comp_mac).
module cic_comp_fir #(
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 16,
    parameter int unsigned TAPS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] data_in,
    output logic                 out_valid,
    output logic signed [DW-1:0] data_out,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 ovf_clr
);
    import cic_comp_pkg::*;

    localparam int unsigned PW = $clog2(TAPS);
    localparam logic [PW-1:0] LAST_TAP = PW'(TAPS - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] tap_q, tap_d;
    logic [PW-1:0] rd_idx;
    logic [DW-1:0] buf_q [TAPS];
    logic [DW-1:0] buf_d [TAPS];
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] data_out_q, data_out_d;
    logic          overrun_q, overrun_d;

    logic                 accept;
    logic                 drop;
    logic                 mac_en;
    logic signed [DW-1:0] mac_x;
    logic signed [CW-1:0] mac_coef;
    logic signed [DW-1:0] mac_result;

    assign accept = in_valid && (state_q != StMac);
    assign drop   = in_valid && (state_q == StMac);
    assign mac_en = (state_q == StMac);

    // The pointer has already advanced past the newest sample, hence the extra -1.
    assign rd_idx   = wr_ptr_q - tap_q - 1'b1;
    assign mac_x    = buf_q[rd_idx];
    assign mac_coef = CW'(COEF[tap_q]);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        buf_d      = buf_q;
        tap_d      = (state_q == StMac) ? tap_q + 1'b1 : '0;
        unique case (state_q)
            StIdle:  if (accept) state_d = StMac;
            StMac:   if (tap_q == LAST_TAP) state_d = StDone;
            StDone:  state_d = accept ? StMac : StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            buf_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        overrun_d   = drop ? 1'b1 : (ovf_clr ? 1'b0 : overrun_q);
        out_valid_d = (state_q == StDone);
        data_out_d  = out_valid_d ? mac_result : data_out_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            tap_q       <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            tap_q       <= tap_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            overrun_q   <= overrun_d;
            buf_q       <= buf_d;
        end
    end

    cic_comp_mac #(
        .DW   (DW),
        .CW   (CW),
        .TAPS (TAPS)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (accept),
        .en_i     (mac_en),
        .x_i      (mac_x),
        .coef_i   (mac_coef),
        .result_o (mac_result)
    );

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign busy      = (state_q == StMac);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench for cic_comp_fir: random and directed stimulus against a convolution model.
`timescale 1ns/1ps
module tb_cic_comp_fir;

    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int TAPS = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic signed [DW-1:0] data_in;
    logic                 out_valid;
    logic signed [DW-1:0] data_out;
    logic                 busy;
    logic                 overrun;
    logic                 ovf_clr;

    cic_comp_fir #(
        .DW   (DW),
        .CW   (CW),
        .TAPS (TAPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out),
        .busy      (busy),
        .overrun   (overrun),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   hist[$];
    int   tap_coef [TAPS] = '{-512, 1536, -4608, 19968, 19968, -4608, 1536, -512};
    int   checks = 0;
    int   errors = 0;
    bit   has_acc;
    int   last_acc;
    bit   ovr_exp;
    int   last_out;
    bit   started = 1'b0;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Convolution of the accepted-sample history with the taps, rounded half up.
    function automatic int model_out();
        longint               sum;
        longint               r;
        logic signed [DW-1:0] w;
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += longint'(tap_coef[k]) * longint'(hist[k]);
        r = (sum + (longint'(1) << (CW - 2))) >>> (CW - 1);
`ifdef CIC_COMP_SAT_EN
        if (r > (longint'(1) << (DW - 1)) - 1) r = (longint'(1) << (DW - 1)) - 1;
        if (r < -(longint'(1) << (DW - 1))) r = -(longint'(1) << (DW - 1));
`endif
        w = r[DW-1:0];
        return int'(w);
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < TAPS; i++) hist.push_back(0);
        exp_q.delete();
        has_acc  = 1'b0;
        last_acc = 0;
        ovr_exp  = 1'b0;
        last_out = 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int x, input bit clr = 1'b0);
        exp_t e;
        in_valid = 1'b1;
        data_in  = DW'(x);
        ovf_clr  = clr;
        if (!has_acc || (cyc - last_acc) >= TAPS + 1) begin
            hist.push_front(x);
            void'(hist.pop_back());
            has_acc  = 1'b1;
            last_acc = cyc;
            e.val    = model_out();
            e.due    = cyc + TAPS + 2;
            exp_q.push_back(e);
            if (clr) ovr_exp = 1'b0;
        end else begin
            ovr_exp = 1'b1;
        end
        tick();
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        ovr_exp = 1'b0;
        tick();
        ovf_clr = 1'b0;
    endtask

    always @(negedge clk) begin
        if (started && !reset) begin
            check("busy", busy, has_acc && cyc > last_acc && cyc <= last_acc + TAPS);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious out_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data_out", data_out, mon_e.val);
                    check("out_valid cycle", cyc, mon_e.due);
                    last_out = mon_e.val;
                end
            end else begin
                check("data_out hold", data_out, last_out);
                if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
                    check("missing out_valid", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [DW-1:0] rv;
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        ovf_clr  = 1'b0;
        model_reset();
        idle(3);
        check("reset out_valid", out_valid, 0);
        check("reset data_out", data_out, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        reset   = 1'b0;
        started = 1'b1;
        idle(2);

        // Impulse response
        send(16384); idle(15);
        for (int i = 0; i < TAPS + 1; i++) begin send(0); idle(15); end

        // Step: settles to exactly the input level
        for (int i = 0; i < 12; i++) begin send(1000); idle(15); end

        // Full-scale input aligned with the coefficient signs
        for (int k = TAPS - 1; k >= 0; k--) begin
            send(tap_coef[k] < 0 ? -32767 : 32767);
            idle(15);
        end

        // Overrun: second strobe 5 cycles later is dropped
        idle(5);
        send(1234); idle(4);
        send(-4321);
        check("overrun set", overrun, 1);
        idle(10);
        send(777); idle(2);
        send(555, 1'b1);
        check("overrun set beats clear", overrun, 1);
        idle(12);
        pulse_clr();
        check("overrun cleared", overrun, 0);

        // Back-to-back at the minimum spacing
        for (int i = 0; i < 10; i++) begin
            rv = DW'($urandom);
            send(rv);
            idle(TAPS);
        end
        check("overrun at min spacing", overrun, 0);
        idle(12);

        // Random spacing, including dropped samples
        for (int i = 0; i < 60; i++) begin
            rv = DW'($urandom);
            send(rv);
            idle($urandom_range(0, 17));
        end
        idle(12);
        check("overrun after random", overrun, ovr_exp);
        pulse_clr();

        // Reset in the middle of a pass, at tap 3
        send(5000); idle(3);
        check("busy before abort", busy, 1);
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        idle(20);
        send(16384); idle(15);
        for (int i = 0; i < TAPS + 1; i++) begin send(0); idle(15); end

        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        check("scoreboard drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Compensation FIR stage placed directly downstream of `cic_filter`. It consumes the decimated CIC output as a single-clock sample stream with a valid strobe. It applies a fixed symmetric TAPS-tap FIR using one time-multiplexed multiply-accumulate unit to flatten the CIC passband droop. The result is emitted with a one-cycle output strobe.

## Interface
- `DW`, 16: signed data width, input and output.
- `CW`, 16: signed coefficient width; unity gain = 2^(CW-1).
- `TAPS`, 8: tap count; power of two, 4..32.
- `clk`  input  1  sole clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  one-cycle strobe; `data_in` is a new CIC output sample.
- `data_in`  input  DW  signed two's-complement sample.
- `out_valid`  output  1  one-cycle strobe; `data_out` is a new filtered sample.
- `data_out`  output  DW  signed result; holds its value between strobes.
- `busy`  output  1  high while a MAC pass is in progress.
- `overrun`  output  1  sticky: a sample arrived while busy and was dropped.
- `ovf_clr`  input  1  clears `overrun`.

## Operation
- Sample buffer:
  - circular, TAPS entries of DW bits, write pointer `wr_ptr` (log2(TAPS) bits, wraps TAPS-1→0).
  - An accepted sample is written at `wr_ptr`; `wr_ptr` increments.
  - Tap k reads entry `wr_ptr_at_accept - k` (mod TAPS), so tap 0 is the newest sample.
- FSM states:
  - IDLE → MAC on an accepted `in_valid`.
  - MAC lasts exactly TAPS cycles, tap index k = 0..TAPS-1, acc += COEF[k]*x[n-k]; after k = TAPS-1 it goes to DONE.
  - DONE lasts 1 cycle, then returns to IDLE.
- Accept rule:
  - `in_valid` is accepted in IDLE or DONE.
  - In MAC, `in_valid` drops the sample, leaves buffer and pointer untouched, and sets `overrun`.
  - An `in_valid` accepted in DONE starts the next pass immediately (DONE → MAC).
- Arithmetic:
  - Accumulator width DW+CW+log2(TAPS), signed; cleared on accept.
  - Result = (acc + 2^(CW-2)) >>> (CW-1) (round half up), reduced to DW per Configuration.
- Default coefficients (CW=16, DC gain exactly 1): -512, 1536, -4608, 19968, 19968, -4608, 1536, -512.
- `overrun`: set has priority over `ovf_clr` in the same cycle.

## Timing
- Reset values:
  - `out_valid` 0, `data_out` 0, `busy` 0, `overrun` 0.
  - Buffer all zero, `wr_ptr` 0, accumulator 0, state IDLE.
- Latency: `in_valid` accepted in cycle T → `out_valid` high in cycle T+TAPS+2, exactly one cycle; `data_out` is updated in the same cycle.
- `busy` is high in cycles T+1..T+TAPS (MAC) and low in IDLE and DONE.
- Minimum sustained input spacing is TAPS+1 cycles. For TAPS=8 this requires CIC os_sel ≥ 4.
- Reset asserted mid-pass: the pass is aborted, no `out_valid`, buffer zeroed.

## Configuration
- `CIC_COMP_SAT_EN` defined: results outside [-2^(DW-1), 2^(DW-1)-1] clamp to the nearest bound.
- Undefined: the low DW bits of the rounded result are taken (two's-complement wrap).

## Structure
- Package `cic_comp_pkg`:
  - coefficient array `COEF`;
  - accumulator width function;
  - FSM state enum (IDLE, MAC, DONE).
- Sub-module `cic_comp_mac`:
  - multiplier, accumulator with clear/enable, rounding and saturation/wrap output stage.
  - The top level holds the buffer, pointer, FSM and flags.

## Test plan
- Impulse: one sample 16384 followed by zeros, spacing 16 → successive outputs -256, 768, -2304, 9984, 9984, -2304, 768, -256, then 0.
- Step: constant 1000, spacing 16 → output reaches and holds exactly 1000 from the 8th output onward.
- Overload: full-scale inputs whose signs match the coefficients, newest first (-,+,-,+,+,-,+,-) × 32767 → 32767 with `CIC_COMP_SAT_EN`, -12290 without.
- Overrun: two `in_valid` 5 cycles apart → second sample dropped, only one `out_valid`, `overrun`=1 until an `ovf_clr` pulse; simultaneous set and clear leaves `overrun`=1.
- Back-to-back at spacing TAPS+1 (9) → every sample produces `out_valid` exactly 10 cycles after its `in_valid`, `overrun` stays 0.
- Reset asserted at MAC tap 3 → no `out_valid`; a subsequent impulse reproduces the impulse-test sequence from zero state.
